// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port fixed-latency memory
// Serialises requests through IDLE/ISSUE/WAIT/RESP; data wins unless fetch has waited MAX_STREAK grants.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          stallF,
  output logic          stallM,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(LAT + 1);
  localparam int SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_dm_q, owner_dm_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          fetch_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Fetch only overrides a pending data request once the streak has saturated.
  assign fetch_win = if_req & (~dm_req | (streak_q == SW'(MAX_STREAK)));

  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req | dm_req) begin
          state_d = ISSUE;
          if (fetch_win) begin
            owner_dm_d = 1'b0;
            we_d       = 1'b0;
            addr_d     = if_addr;
            streak_d   = '0;
          end else begin
            owner_dm_d = 1'b1;
            we_d       = dm_we;
            addr_d     = dm_addr;
            wdata_d    = dm_wdata;
            if (!if_req)
              streak_d = '0;
            else if (streak_q != SW'(MAX_STREAK))
              streak_d = streak_q + SW'(1);
          end
        end
      end
      ISSUE: begin
        cnt_d   = CW'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!owner_dm_q)
            if_rdata_d = mem_rdata;
          else if (!we_q)
            dm_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = (state_q == ISSUE);
    mem_we    = (state_q == ISSUE) & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ack    = (state_q == RESP) & ~owner_dm_q;
    dm_ack    = (state_q == RESP) & owner_dm_q;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    stallF    = if_req & ~if_ack;
    stallM    = dm_req & ~dm_ack;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Vector table plus streak, reset-abort and LAT=1/5 sequences, checked through an ack scoreboard.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack, stallF, stallM, mem_en, mem_we;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        r1_req, r1_ack, r1_dack, r1_sf, r1_sm, r1_en, r1_we;
  logic [31:0] r1_rd, r1_drd, r1_maddr, r1_mwd, r1_mrd;
  logic        r5_req, r5_ack, r5_dack, r5_sf, r5_sm, r5_en, r5_we;
  logic [31:0] r5_rd, r5_drd, r5_maddr, r5_mwd, r5_mrd;
  logic [31:0] aux_addr;

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT), .MAX_STREAK(4)) u_dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .stallF(stallF), .stallM(stallM), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .MAX_STREAK(4)) u_dut1 (
    .clk(clk), .reset(reset), .if_req(r1_req), .if_addr(aux_addr), .if_ack(r1_ack), .if_rdata(r1_rd),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0), .dm_ack(r1_dack),
    .dm_rdata(r1_drd), .stallF(r1_sf), .stallM(r1_sm), .mem_en(r1_en), .mem_we(r1_we),
    .mem_addr(r1_maddr), .mem_wdata(r1_mwd), .mem_rdata(r1_mrd));

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(5), .MAX_STREAK(4)) u_dut5 (
    .clk(clk), .reset(reset), .if_req(r5_req), .if_addr(aux_addr), .if_ack(r5_ack), .if_rdata(r5_rd),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0), .dm_ack(r5_dack),
    .dm_rdata(r5_drd), .stallF(r5_sf), .stallM(r5_sm), .mem_en(r5_en), .mem_we(r5_we),
    .mem_addr(r5_maddr), .mem_wdata(r5_mwd), .mem_rdata(r5_mrd));

  function automatic logic [31:0] mdata(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory models: read data appears exactly LAT cycles after the strobe, zero otherwise.
  logic [7:0]  v0 = '0, v1 = '0, v5 = '0;
  logic [31:0] a0[8], a1[8], a5[8];
  always @(posedge clk) begin
    v0 <= {v0[6:0], mem_en};
    v1 <= {v1[6:0], r1_en};
    v5 <= {v5[6:0], r5_en};
    a0[0] <= mem_addr;
    a1[0] <= r1_maddr;
    a5[0] <= r5_maddr;
    for (int k = 1; k < 8; k++) begin
      a0[k] <= a0[k-1];
      a1[k] <= a1[k-1];
      a5[k] <= a5[k-1];
    end
  end
  assign mem_rdata = v0[LAT-1] ? mdata(a0[LAT-1]) : 32'h0;
  assign r1_mrd    = v1[0] ? mdata(a1[0]) : 32'h0;
  assign r5_mrd    = v5[4] ? mdata(a5[4]) : 32'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;
  } sb_t;
  sb_t sb[$];

  sb_t m;
  always @(negedge clk) begin
    if (mem_en) begin
      if (sb.size() == 0) chk("mem_en_unexpected", 32'(mem_en), 32'h0);
      else begin
        chk("mem_we", 32'(mem_we), 32'(sb[0].we));
        chk("mem_addr", mem_addr, sb[0].addr);
        if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
        chk("mem_en_cycle", 32'(cyc), 32'(sb[0].ack_cyc - LAT - 1));
      end
    end
    if (if_ack || dm_ack) begin
      chk("single_ack", 32'(if_ack & dm_ack), 32'h0);
      if (sb.size() == 0) chk("ack_unexpected", 32'h1, 32'h0);
      else begin
        m = sb.pop_front();
        chk("ack_port_dm", 32'(dm_ack), 32'(m.is_dm));
        chk("ack_cycle", 32'(cyc), 32'(m.ack_cyc));
        if (m.is_dm) chk("dm_rdata", dm_rdata, m.rdata);
        else chk("if_rdata", if_rdata, m.rdata);
      end
    end
  end

  typedef struct {
    bit          ifr;
    logic [31:0] ia;
    bit          dr;
    bit          we;
    logic [31:0] da;
    logic [31:0] wd;
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
    int          exp_sf;
    int          exp_sm;
  } vec_t;
  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int  c, sf, sm;
    bit  fdone, ddone;
    sb_t e;
    c = cyc; sf = 0; sm = 0;
    if_req = v.ifr; if_addr = v.ia; dm_req = v.dr; dm_we = v.we; dm_addr = v.da; dm_wdata = v.wd;
    if (v.dr) begin
      e = '{1'b1, v.we, v.da, v.wd, v.exp_dm, c + LAT + 2};
      sb.push_back(e);
    end
    if (v.ifr) begin
      e = '{1'b0, 1'b0, v.ia, 32'h0, v.exp_if, v.dr ? c + 2*LAT + 5 : c + LAT + 2};
      sb.push_back(e);
    end
    fdone = !v.ifr; ddone = !v.dr;
    for (int k = 0; k < 40 && !(fdone && ddone); k++) begin
      @(negedge clk);
      sf += int'(stallF);
      sm += int'(stallM);
      if (if_ack) fdone = 1'b1;
      if (dm_ack) ddone = 1'b1;
      @(posedge clk); #1;
      if (fdone) if_req = 1'b0;
      if (ddone) dm_req = 1'b0;
    end
    chk("vec_done", 32'(fdone && ddone), 32'h1);
    chk("stallF_cycles", 32'(sf), 32'(v.exp_sf));
    chk("stallM_cycles", 32'(sm), 32'(v.exp_sm));
    @(posedge clk); #1;
  endtask

  task automatic run_streak();
    int  c;
    sb_t e;
    c = cyc;
    if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      e = '{1'b1, 1'b0, 32'h300 + 32'(4*k), 32'h0, mdata(32'h300 + 32'(4*k)), c + 4 + 5*k};
      sb.push_back(e);
    end
    e = '{1'b0, 1'b0, 32'h200, 32'h0, mdata(32'h200), c + 24};
    sb.push_back(e);
    for (int k = 4; k < 6; k++) begin
      e = '{1'b1, 1'b0, 32'h300 + 32'(4*k), 32'h0, mdata(32'h300 + 32'(4*k)), c + 9 + 5*k};
      sb.push_back(e);
    end
    fork
      begin
        bit got;
        for (int k = 0; k < 6; k++) begin
          got = 1'b0;
          dm_addr = 32'h300 + 32'(4*k);
          for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = dm_ack;
            @(posedge clk); #1;
          end
          chk("streak_dm_ack", 32'(got), 32'h1);
        end
        dm_req = 1'b0;
      end
      begin
        bit fgot;
        fgot = 1'b0;
        for (int n = 0; n < 60 && !fgot; n++) begin
          @(negedge clk);
          fgot = if_ack;
          @(posedge clk); #1;
        end
        if_req = 1'b0;
        chk("streak_if_ack", 32'(fgot), 32'h1);
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic run_reset_abort();
    sb_t  e;
    vec_t v;
    e = '{1'b1, 1'b0, 32'h500, 32'h0, mdata(32'h500), cyc + LAT + 2};
    sb.push_back(e);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    sb.delete();
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_dm_ack", 32'(dm_ack), 32'h0);
    chk("rst_if_ack", 32'(if_ack), 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_stallM", 32'(stallM), 32'h1);
    dm_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    v = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 32'h0500FAFF, 0, 4};
    run_vec(v);
  endtask

  task automatic run_aux_latency();
    int          c, c1, c5;
    logic [31:0] ad;
    for (int t = 0; t < 2; t++) begin
      ad = (t == 0) ? 32'h40 : 32'h60;
      aux_addr = ad; c = cyc; c1 = -1; c5 = -1;
      r1_req = 1'b1; r5_req = 1'b1;
      for (int n = 0; n < 20 && (r1_req || r5_req); n++) begin
        @(negedge clk);
        if (r1_ack) begin c1 = cyc; chk("lat1_rdata", r1_rd, mdata(ad)); end
        if (r5_ack) begin c5 = cyc; chk("lat5_rdata", r5_rd, mdata(ad)); end
        @(posedge clk); #1;
        if (c1 >= 0) r1_req = 1'b0;
        if (c5 >= 0) r5_req = 1'b0;
      end
      chk("lat1_ack_cycle", 32'(c1), 32'(c + 3));
      chk("lat5_ack_cycle", 32'(c5), 32'(c + 7));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,    32'hDEADBEEF, 32'h0,        4, 0};
    vecs[1] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,    32'h0044FFBB, 32'h0100FEFF, 9, 4};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h8,   32'h1234, 32'h0,        32'h0100FEFF, 0, 4};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h2C,  32'h0,    32'h0,        32'h002CFFD3, 0, 4};
    vecs[4] = '{1'b1, 32'h48, 1'b1, 1'b1, 32'hC,   32'hCAFE, 32'h0048FFB7, 32'h002CFFD3, 9, 4};

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    r1_req = 1'b0; r5_req = 1'b0; aux_addr = '0;
    @(posedge clk); #1;
    chk("reset_mem_en", 32'(mem_en), 32'h0);
    chk("reset_mem_we", 32'(mem_we), 32'h0);
    chk("reset_if_ack", 32'(if_ack), 32'h0);
    chk("reset_dm_ack", 32'(dm_ack), 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_if_rdata", if_rdata, 32'h0);
    chk("reset_dm_rdata", dm_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    run_streak();
    run_reset_abort();
    run_aux_latency();

    repeat (5) begin @(posedge clk); #1; end
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
